// File: rtl/mealy_step_ctrl.sv
// ============================================================================
// mealy_step_ctrl : button conditioning, IDLE/RUN/HALT step control, capture
// Rev 1.0
// ============================================================================
`default_nettype none

module mealy_step_ctrl #(
  parameter int DEB_CYCLES = 4,
  parameter int TICK_DIV   = 8,
  parameter int STATE_W    = 3,
  parameter int CNT_W      = 8,
  parameter int HIST_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_step,
  input  logic               btn_run,
  input  logic               clr,
  input  logic               halt_en,
  input  logic [STATE_W-1:0] halt_state,
  input  logic [STATE_W-1:0] mach_state,
  input  logic               mach_out,
  output logic               step,
  output logic               mach_load,
  output logic               running,
  output logic               halted,
  output logic [CNT_W-1:0]   step_count,
  output logic [HIST_W-1:0]  out_hist
);

  localparam int DCW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam int TCW = $clog2(TICK_DIV);
  localparam logic [DCW-1:0]   C_DEB_LAST  = DCW'(DEB_CYCLES - 1);
  localparam logic [TCW-1:0]   C_TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {btn_run, btn_step};

  // Index 0 is the step button, index 1 the run/stop button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0]     sync_q;
    logic           deb_q;
    logic [DCW-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q <= '0;
        deb_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        sync_q <= {sync_q[0], w_raw[gi]};
        if (sync_q[1] == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == C_DEB_LAST) begin
          deb_q <= sync_q[1];
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign w_press[gi] = sync_q[1] & ~deb_q & (cnt_q == C_DEB_LAST);
  end

  state_t             state_q;
  logic [TCW-1:0]     tick_q;
  logic               step_q;
  logic               step_dly_q;
  logic               mach_load_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [HIST_W-1:0]  hist_q;
  logic               w_bp;
  logic               w_tick;

  assign count_d = (count_q == C_CNT_MAX) ? count_q : count_q + 1'b1;
  assign w_bp    = step_dly_q & halt_en & (mach_state == halt_state);
  assign w_tick  = (tick_q == C_TICK_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      step_q      <= 1'b0;
      step_dly_q  <= 1'b0;
      mach_load_q <= 1'b0;
      count_q     <= '0;
      hist_q      <= '0;
    end else begin
      mach_load_q <= clr;
      if (clr) begin
        state_q    <= S_IDLE;
        tick_q     <= '0;
        step_q     <= 1'b0;
        step_dly_q <= 1'b0;
        count_q    <= '0;
        hist_q     <= '0;
      end else begin
        step_dly_q <= step_q;
        step_q     <= 1'b0;
        // The machine has already advanced when step_dly_q is high.
        if (step_dly_q) begin
          hist_q  <= {hist_q[HIST_W-2:0], mach_out};
          count_q <= count_d;
        end
        case (state_q)
          S_IDLE: begin
            if (w_bp) begin
              state_q <= S_HALT;
            end else if (w_press[1]) begin
              state_q <= S_RUN;
              tick_q  <= '0;
            end else if (w_press[0] && !step_q && !step_dly_q) begin
              step_q <= 1'b1;
            end
          end
          S_RUN: begin
            if (w_bp) begin
              state_q <= S_HALT;
              tick_q  <= '0;
            end else if (w_press[1]) begin
              state_q <= S_IDLE;
              tick_q  <= '0;
            end else begin
              tick_q <= w_tick ? '0 : tick_q + 1'b1;
              step_q <= w_tick;
            end
          end
          S_HALT: begin
            state_q <= S_HALT;
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign step       = step_q;
  assign mach_load  = mach_load_q;
  assign running    = (state_q == S_RUN);
  assign halted     = (state_q == S_HALT);
  assign step_count = count_q;
  assign out_hist   = hist_q;

endmodule

`default_nettype wire

// File: tb/tb_mealy_step_ctrl.sv
// ============================================================================
// tb_mealy_step_ctrl : randomized bench with an action-level reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mealy_step_ctrl;

  localparam int DEB  = 4;
  localparam int TDIV = 8;
  localparam int SW   = 3;
  localparam int CW   = 3;
  localparam int HW   = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          btn_step, btn_run, clr, halt_en;
  logic [SW-1:0] halt_state, mach_state;
  logic          mach_out;
  logic          step, mach_load, running, halted;
  logic [CW-1:0] step_count;
  logic [HW-1:0] out_hist;
  logic          sw_in;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mealy_step_ctrl #(
    .DEB_CYCLES(DEB), .TICK_DIV(TDIV), .STATE_W(SW), .CNT_W(CW), .HIST_W(HW)
  ) dut (
    .clk(clk), .reset(reset), .btn_step(btn_step), .btn_run(btn_run),
    .clr(clr), .halt_en(halt_en), .halt_state(halt_state),
    .mach_state(mach_state), .mach_out(mach_out), .step(step),
    .mach_load(mach_load), .running(running), .halted(halted),
    .step_count(step_count), .out_hist(out_hist)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Demo machine: three states, sw_in selects direction and output rule.
  function automatic int m_next(input int s, input bit sw);
    return sw ? (s + 2) % 3 : (s + 1) % 3;
  endfunction
  function automatic int m_out(input int s, input bit sw);
    return sw ? ((s == 0) ? 1 : 0) : 1;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mach_state <= '0;
      mach_out   <= 1'b0;
    end else if (mach_load) begin
      mach_state <= '0;
      mach_out   <= 1'b0;
    end else if (step) begin
      mach_state <= SW'(m_next(int'(mach_state), sw_in));
      mach_out   <= 1'(m_out(int'(mach_state), sw_in));
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pulse start times, pulse widths, flag edges, mach_load window.
  int pulses[$];
  int step_w = 0, ml_cur = 0, ml_w = -1, ml_rise = -1;
  int t_rise_run = -1, t_fall_run = -1, t_halt = -1;
  bit prev_step = 0, prev_run = 0, prev_halt = 0, prev_ml = 0;

  always @(negedge clk) begin
    if (step === 1'b1) begin
      if (!prev_step) pulses.push_back(cyc);
      step_w++;
    end else if (prev_step) begin
      check_eq("step_width", step_w, 1);
      step_w = 0;
    end
    if (running && !prev_run) t_rise_run = cyc;
    if (!running && prev_run) t_fall_run = cyc;
    if (halted && !prev_halt) t_halt = cyc;
    if (mach_load) begin
      if (!prev_ml) begin ml_rise = cyc; ml_cur = 0; end
      ml_cur++;
    end else if (prev_ml) begin
      ml_w = ml_cur;
    end
    prev_step = (step === 1'b1);
    prev_run  = (running === 1'b1);
    prev_halt = (halted === 1'b1);
    prev_ml   = (mach_load === 1'b1);
  end

  // Reference model: mode 0 idle, 1 run, 2 halt.
  int e_mode = 0, e_cnt = 0, e_hist = 0, e_ms = 0;

  task automatic apply_step();
    int o;
    o      = m_out(e_ms, sw_in);
    e_ms   = m_next(e_ms, sw_in);
    e_hist = ((e_hist << 1) | o) & ((1 << HW) - 1);
    if (e_cnt < CNT_MAX) e_cnt++;
    if (halt_en && (e_ms == int'(halt_state))) e_mode = 2;
  endtask

  task automatic model_clear();
    e_mode = 0; e_cnt = 0; e_hist = 0; e_ms = 0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".count"}, int'(step_count), e_cnt);
    check_eq({tag, ".hist"}, int'(out_hist), e_hist);
    check_eq({tag, ".running"}, int'(running), (e_mode == 1) ? 1 : 0);
    check_eq({tag, ".halted"}, int'(halted), (e_mode == 2) ? 1 : 0);
    check_eq({tag, ".mstate"}, int'(mach_state), e_ms);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic drive(input bit ds, input bit dr, input bit v);
    if (ds) btn_step = v;
    if (dr) btn_run  = v;
  endtask

  // One clean press event; bounce runs stay shorter than the debounce window.
  task automatic press(input bit ds, input bit dr, input int bmode, output int t_edge);
    int nb;
    nb = (bmode == 2) ? 10 : (bmode == 1) ? $urandom_range(0, 4) : 0;
    for (int i = 0; i < nb; i++) begin
      drive(ds, dr, 1'b1); cycles((bmode == 2) ? 1 : $urandom_range(1, DEB - 2));
      drive(ds, dr, 1'b0); cycles((bmode == 2) ? 1 : $urandom_range(1, DEB - 2));
    end
    drive(ds, dr, 1'b1);
    t_edge = cyc;
    cycles(DEB + 8);
    nb = (bmode != 0) ? $urandom_range(0, 3) : 0;
    for (int i = 0; i < nb; i++) begin
      drive(ds, dr, 1'b0); cycles($urandom_range(1, DEB - 2));
      drive(ds, dr, 1'b1); cycles($urandom_range(1, DEB - 2));
    end
    drive(ds, dr, 1'b0);
    cycles(DEB + 8);
  endtask

  task automatic do_step_press(input int bmode);
    int te;
    pulses.delete();
    press(1'b1, 1'b0, bmode, te);
    if (e_mode == 0) begin
      check_eq("step.pulses", pulses.size(), 1);
      if (pulses.size() > 0)
        check_eq("step.latency_ok",
                 (pulses[0] >= te + DEB + 2 && pulses[0] <= te + DEB + 4) ? 1 : 0, 1);
      apply_step();
    end else begin
      check_eq("step.ignored", pulses.size(), 0);
    end
    check_state("step");
  endtask

  task automatic do_clr(input int n);
    int c;
    ml_rise = -1; ml_w = -1;
    clr = 1'b1; c = cyc;
    cycles(n);
    clr = 1'b0;
    cycles(3);
    check_eq("clr.load_rise", ml_rise, c + 1);
    check_eq("clr.load_width", ml_w, n);
    model_clear();
    check_state("clr");
  endtask

  task automatic run_session(input int extra, input bit both);
    int te, ts, tr, tf, p, halt_at;
    int exp_p[$];
    pulses.delete();
    t_rise_run = -1; t_fall_run = -1; t_halt = -1;
    if (e_mode == 2) begin
      press(1'b0, 1'b1, 1, te);
      check_eq("halt.run_ignored", pulses.size(), 0);
      check_state("halt");
      return;
    end
    press(both, 1'b1, both ? 0 : 1, te);
    tr = t_rise_run;
    check_eq("run.enter_ok", (tr >= te + DEB + 2 && tr <= te + DEB + 4) ? 1 : 0, 1);
    if (tr < 0) tr = te + DEB + 2;
    e_mode = 1;
    cycles(extra);
    press(1'b0, 1'b1, 1, ts);
    tf = (t_fall_run < 0) ? cyc : t_fall_run;
    halt_at = -1;
    for (int k = 1; k < 1000; k++) begin
      p = tr + TDIV * k;
      if (p > tf - 1) break;
      exp_p.push_back(p);
      apply_step();
      if (e_mode == 2) begin
        halt_at = p + 2;
        break;
      end
    end
    if (e_mode == 1) begin
      e_mode = 0;
      check_eq("run.stop_ok", (tf >= ts + DEB + 2 && tf <= ts + DEB + 4) ? 1 : 0, 1);
    end else begin
      check_eq("run.halt_time", t_halt, halt_at);
    end
    check_eq("run.pulse_count", pulses.size(), exp_p.size());
    for (int i = 0; i < pulses.size() && i < exp_p.size(); i++)
      check_eq("run.pulse_time", pulses[i], exp_p[i]);
    check_state("run");
  endtask

  task automatic reset_during_step();
    int te, n;
    press(1'b0, 1'b1, 0, te);
    n = 0;
    while (step !== 1'b1 && n < 4 * TDIV) begin
      @(negedge clk);
      n++;
    end
    check_eq("rst.saw_step", int'(step === 1'b1), 1);
    #2 reset = 1'b1;
    #1;
    check_eq("rst.step", int'(step), 0);
    check_eq("rst.load", int'(mach_load), 0);
    check_eq("rst.running", int'(running), 0);
    check_eq("rst.halted", int'(halted), 0);
    check_eq("rst.count", int'(step_count), 0);
    check_eq("rst.hist", int'(out_hist), 0);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    cycles(4);
    check_state("rst.after");
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    reset = 1'b1; btn_step = 1'b0; btn_run = 1'b0; clr = 1'b0;
    halt_en = 1'b0; halt_state = '0; sw_in = 1'b0;
    cycles(3);
    check_eq("reset.step", int'(step), 0);
    check_eq("reset.load", int'(mach_load), 0);
    check_state("reset");
    reset = 1'b0;
    cycles(3);
    check_state("post_reset");

    // Three clean single steps from state 0 with sw_in low.
    for (int i = 0; i < 3; i++) do_step_press(0);
    check_eq("single.hist3", int'(out_hist[2:0]), 7);

    do_clr(1);
    do_step_press(2);

    do_clr(1);
    run_session(20, 1'b0);

    // Breakpoint on state 2 while running.
    do_clr(1);
    halt_en = 1'b1; halt_state = SW'(2); sw_in = 1'b0;
    run_session(30, 1'b0);
    check_eq("bp.halted", int'(halted), 1);
    do_step_press(1);
    run_session(0, 1'b0);
    do_clr(1);
    halt_en = 1'b0;

    for (int i = 0; i < CNT_MAX + 2; i++) do_step_press(1);
    check_eq("sat.count", int'(step_count), CNT_MAX);

    do_clr(3);
    run_session(12, 1'b1);

    do_clr(1);
    reset_during_step();

    for (int i = 0; i < 40; i++) begin
      sw_in      = 1'($urandom_range(0, 1));
      halt_en    = ($urandom_range(0, 3) == 0);
      halt_state = SW'($urandom_range(0, 2));
      act = $urandom_range(0, 6);
      if (act <= 3)      do_step_press(1);
      else if (act <= 5) run_session($urandom_range(0, 40), ($urandom_range(0, 3) == 0));
      else               do_clr($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
